number_stream_arbiter: RTL and testbench

- Shares one downstream word-stream consumer between NUM_REQ producers.
- A producer is typically a number-buffering stage that replays a BITS_IN_NUM-bit number as REGISTER_SIZE-bit words.
- Grants are atomic per full number: once a producer is granted, all WORDS_PER_NUM words of its number pass before any other producer is served.
- Grant order is round-robin; the block forwards data/valid downstream and routes the consumer's "consumed" strobe back to the granted producer only.

---
 rtl/number_stream_arbiter.sv | 132 +++++++++++++
 tb/tb_number_stream_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/number_stream_arbiter.sv
// Round-robin arbiter that shares one word-stream consumer between NUM_REQ producers,
// granting each producer for one complete number of WORDS_PER_NUM words at a time.
module number_stream_arbiter #(
  parameter int BITS_IN_NUM   = 4096,
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_REQ       = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_REQ-1:0]               req_in,
  input  logic [NUM_REQ*REGISTER_SIZE-1:0] data_in,
  input  logic [NUM_REQ-1:0]               data_valid_in,
  input  logic                             prev_data_consumed_in,
  output logic [NUM_REQ-1:0]               grant_out,
  output logic [NUM_REQ-1:0]               consumed_out,
  output logic [REGISTER_SIZE-1:0]         data_out,
  output logic                             data_valid_out,
  output logic                             busy_out,
  output logic                             protocol_error_out
);

  localparam int WORDS_PER_NUM = BITS_IN_NUM / REGISTER_SIZE;
  localparam int CNT_W = (WORDS_PER_NUM > 1) ? $clog2(WORDS_PER_NUM) : 1;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_NUM - 1);
  localparam logic [IDX_W-1:0] LAST_REQ  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, STREAM, RELEASE} state_t;

  state_t                   state, state_n;
  logic [CNT_W-1:0]         word_cnt, word_cnt_n;
  logic [IDX_W-1:0]         cur_idx, cur_idx_n;
  logic [IDX_W-1:0]         last_idx, last_idx_n;
  logic [IDX_W-1:0]         sel;
  logic                     sel_found;
  logic [NUM_REQ-1:0]       grant_n;
  logic [NUM_REQ-1:0]       cur_onehot;
  logic [REGISTER_SIZE-1:0] data_n, cur_data;
  logic                     data_valid_n, error_n;
  logic                     cur_valid, cur_req, last_word;

  // Scan starts just after the producer that finished last, so nobody is starved.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_found && req_in[(int'(last_idx) + k) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel       = IDX_W'((int'(last_idx) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    cur_onehot = NUM_REQ'(1) << cur_idx;
    cur_data   = data_in[int'(cur_idx)*REGISTER_SIZE +: REGISTER_SIZE];
    cur_valid  = data_valid_in[cur_idx];
    cur_req    = req_in[cur_idx];
    last_word  = cur_valid && (word_cnt == LAST_WORD);
  end

  always_comb begin
    state_n      = state;
    word_cnt_n   = word_cnt;
    cur_idx_n    = cur_idx;
    last_idx_n   = last_idx;
    grant_n      = grant_out;
    data_n       = data_out;
    data_valid_n = data_valid_out;
    error_n      = protocol_error_out;
    case (state)
      IDLE: begin
        if (data_valid_in != '0) error_n = 1'b1;
        if (sel_found) begin
          grant_n   = NUM_REQ'(1) << sel;
          cur_idx_n = sel;
          state_n   = STREAM;
        end else begin
          grant_n = '0;
        end
      end
      STREAM: begin
        data_n       = cur_data;
        data_valid_n = cur_valid;
        // A dropped request is tolerated only on the cycle that carries the last word.
        if (((data_valid_in & ~cur_onehot) != '0) || (!cur_req && !last_word))
          error_n = 1'b1;
        if (cur_valid) begin
          if (last_word) begin
            word_cnt_n = '0;
            last_idx_n = cur_idx;
            grant_n    = '0;
            state_n    = RELEASE;
          end else begin
            word_cnt_n = word_cnt + CNT_W'(1);
          end
        end
      end
      RELEASE: begin
        data_valid_n = 1'b0;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= IDLE;
      word_cnt           <= '0;
      cur_idx            <= '0;
      last_idx           <= LAST_REQ;
      grant_out          <= '0;
      data_out           <= '0;
      data_valid_out     <= 1'b0;
      protocol_error_out <= 1'b0;
    end else begin
      state              <= state_n;
      word_cnt           <= word_cnt_n;
      cur_idx            <= cur_idx_n;
      last_idx           <= last_idx_n;
      grant_out          <= grant_n;
      data_out           <= data_n;
      data_valid_out     <= data_valid_n;
      protocol_error_out <= error_n;
    end
  end

  assign busy_out     = (state != IDLE);
  assign consumed_out = (state == STREAM) ? (cur_onehot & {NUM_REQ{prev_data_consumed_in}}) : '0;

endmodule

// File: tb/tb_number_stream_arbiter.sv
// Bench for number_stream_arbiter: directed scenarios with literal expectations plus
// randomized producers, all checked every cycle against a transaction-level model.
module tb_number_stream_arbiter;

  localparam int BITS = 128;
  localparam int RS   = 32;
  localparam int NR   = 2;
  localparam int W    = BITS / RS;
  localparam logic [RS-1:0] DEAD = 32'h0000DEAD;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [NR-1:0]     req_in;
  logic [NR*RS-1:0]  data_in;
  logic [NR-1:0]     data_valid_in;
  logic              prev_data_consumed_in;
  logic [NR-1:0]     grant_out;
  logic [NR-1:0]     consumed_out;
  logic [RS-1:0]     data_out;
  logic              data_valid_out;
  logic              busy_out;
  logic              protocol_error_out;

  logic [RS-1:0]     din [NR];

  number_stream_arbiter #(.BITS_IN_NUM(BITS), .REGISTER_SIZE(RS), .NUM_REQ(NR)) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .req_in                (req_in),
    .data_in               (data_in),
    .data_valid_in         (data_valid_in),
    .prev_data_consumed_in (prev_data_consumed_in),
    .grant_out             (grant_out),
    .consumed_out          (consumed_out),
    .data_out              (data_out),
    .data_valid_out        (data_valid_out),
    .busy_out              (busy_out),
    .protocol_error_out    (protocol_error_out)
  );

  always #5 clk_in = ~clk_in;

  always_comb
    for (int i = 0; i < NR; i++) data_in[i*RS +: RS] = din[i];

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  // Model: who owns the consumer (-1 = nobody), words taken so far, release cycle pending.
  int            m_owner, m_cnt, m_last;
  bit            m_rel, m_dv, m_err;
  logic [NR-1:0] m_grant;
  logic [RS-1:0] m_dout;

  int sent [NR];
  bit want [NR];
  int nums [NR];
  int lw_step;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [NR-1:0] exp_consumed();
    if (m_owner >= 0) return NR'(prev_data_consumed_in) << m_owner;
    return '0;
  endfunction

  task automatic model_edge();
    bit found;
    bit is_last;
    if (rst_in) begin
      m_owner = -1; m_rel = 0; m_cnt = 0; m_last = NR - 1;
      m_grant = '0; m_dout = '0; m_dv = 0; m_err = 0;
    end else if (m_rel) begin
      m_dv  = 0;
      m_rel = 0;
    end else if (m_owner < 0) begin
      if (data_valid_in != '0) m_err = 1;
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        if (!found && req_in[(m_last + k) % NR]) begin
          found   = 1;
          m_owner = (m_last + k) % NR;
        end
      end
      m_grant = found ? (NR'(1) << m_owner) : '0;
    end else begin
      m_dout = din[m_owner];
      m_dv   = data_valid_in[m_owner];
      for (int j = 0; j < NR; j++)
        if (j != m_owner && data_valid_in[j]) m_err = 1;
      is_last = data_valid_in[m_owner] && (m_cnt == W - 1);
      if (!req_in[m_owner] && !is_last) m_err = 1;
      if (data_valid_in[m_owner]) begin
        m_cnt++;
        if (m_cnt == W) begin
          m_cnt   = 0;
          m_last  = m_owner;
          m_owner = -1;
          m_grant = '0;
          m_rel   = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [NR-1:0] req, input logic [NR-1:0] valid,
                               input logic [RS-1:0] d0, input logic [RS-1:0] d1, input logic cons);
    rst_in                = rst;
    req_in                = req;
    data_valid_in         = valid;
    din[0]                = d0;
    din[1]                = d1;
    prev_data_consumed_in = cons;
    #1;
    checkOutput("consumed_out", consumed_out, exp_consumed());
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    cycle++;
    model_edge();
    checkOutput("grant_out", grant_out, m_grant);
    checkOutput("data_out", data_out, m_dout);
    checkOutput("data_valid_out", data_valid_out, m_dv);
    checkOutput("busy_out", busy_out, (m_owner >= 0) || m_rel);
    checkOutput("protocol_error_out", protocol_error_out, m_err);
    checkOutput("no_dead_word", data_valid_out && (data_out == DEAD), 0);
  endtask

  task automatic do_reset();
    applyStimulus(1, '0, '0, '0, '0, 0);
    step();
    for (int i = 0; i < NR; i++) begin
      sent[i] = 0; want[i] = 0; nums[i] = 0;
    end
    lw_step = -1;
  endtask

  // Behavioural producers: request, stream W words while granted, then maybe re-request.
  task automatic drive_cycle(input bit hold, input bit inject);
    logic [NR-1:0] r, v;
    logic [RS-1:0] d [NR];
    for (int i = 0; i < NR; i++) begin
      if (sent[i] == W && !grant_out[i]) begin
        sent[i] = 0;
        nums[i]++;
        if (!hold && $urandom_range(0, 1) == 1) want[i] = 0;
      end
      if (!want[i] && (hold || $urandom_range(0, 3) == 0)) want[i] = 1;
      v[i] = 1'b0;
      d[i] = $urandom;
      if (grant_out[i] && want[i] && sent[i] < W && (hold || $urandom_range(0, 2) != 0)) begin
        v[i] = 1'b1;
        d[i] = {8'(i), 8'(nums[i]), 8'h5A, 8'(sent[i])};
        sent[i]++;
        if (sent[i] == W) lw_step = cycle + 1;
      end else if (inject && !grant_out[i] && $urandom_range(0, 15) == 0) begin
        v[i] = 1'b1;
        d[i] = DEAD;
      end
      r[i] = want[i];
    end
    applyStimulus(0, r, v, d[0], d[1], 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order[$];
    logic [NR-1:0] prev_g;

    // Reset values
    do_reset();
    checkOutput("reset_grant", grant_out, 2'b00);
    checkOutput("reset_valid", data_valid_out, 0);
    checkOutput("reset_data", data_out, 0);
    checkOutput("reset_busy", busy_out, 0);
    checkOutput("reset_error", protocol_error_out, 0);

    // Single requester
    applyStimulus(0, 2'b01, 2'b00, '0, '0, 0);
    step();
    checkOutput("single_grant", grant_out, 2'b01);
    for (int k = 0; k < W; k++) begin
      applyStimulus(0, 2'b01, 2'b01, 32'hA0 + k, '0, 1);
      checkOutput("single_consumed", consumed_out, 2'b01);
      step();
      checkOutput("single_data", data_out, 32'hA0 + k);
      checkOutput("single_valid", data_valid_out, 1);
      checkOutput("single_grant_hold", grant_out, (k == W - 1) ? 2'b00 : 2'b01);
    end
    checkOutput("single_busy_release", busy_out, 1);
    applyStimulus(0, 2'b00, 2'b00, '0, '0, 1);
    checkOutput("single_consumed_release", consumed_out, 2'b00);
    step();
    checkOutput("single_busy_idle", busy_out, 0);
    checkOutput("single_valid_idle", data_valid_out, 0);

    // Isolation: producer 1 pushes 0xDEAD while producer 0 holds the grant
    do_reset();
    applyStimulus(0, 2'b01, 2'b00, '0, '0, 0);
    step();
    for (int k = 0; k < W; k++) begin
      applyStimulus(0, 2'b01, 2'b11, 32'hB0 + k, DEAD, 1);
      checkOutput("iso_consumed1", consumed_out[1], 0);
      step();
      checkOutput("iso_data", data_out, 32'hB0 + k);
      checkOutput("iso_error", protocol_error_out, 1);
    end
    applyStimulus(0, 2'b00, 2'b00, '0, '0, 0);
    step();
    applyStimulus(0, 2'b00, 2'b00, '0, '0, 0);
    step();
    checkOutput("iso_error_sticky", protocol_error_out, 1);

    // Reset mid-stream, then a fresh full-length grant
    applyStimulus(0, 2'b01, 2'b00, '0, '0, 0);
    step();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 2'b01, 2'b01, 32'hC0 + k, '0, 1);
      step();
    end
    applyStimulus(1, 2'b01, 2'b01, 32'hC2, '0, 1);
    step();
    checkOutput("mid_reset_grant", grant_out, 2'b00);
    checkOutput("mid_reset_valid", data_valid_out, 0);
    checkOutput("mid_reset_busy", busy_out, 0);
    checkOutput("mid_reset_error", protocol_error_out, 0);
    applyStimulus(0, 2'b01, 2'b00, '0, '0, 0);
    step();
    checkOutput("mid_regrant", grant_out, 2'b01);
    for (int k = 0; k < W; k++) begin
      applyStimulus(0, 2'b01, 2'b01, 32'hD0 + k, '0, 0);
      step();
      checkOutput("mid_full_data", data_out, 32'hD0 + k);
      checkOutput("mid_full_grant", grant_out, (k == W - 1) ? 2'b00 : 2'b01);
    end

    // Consumed routing with grant to producer 1
    do_reset();
    applyStimulus(0, 2'b10, 2'b00, '0, '0, 1);
    checkOutput("route_idle", consumed_out, 2'b00);
    step();
    for (int k = 0; k < W; k++) begin
      applyStimulus(0, 2'b10, 2'b10, '0, 32'hE0 + k, 1);
      checkOutput("route_stream", consumed_out, 2'b10);
      step();
    end
    applyStimulus(0, 2'b00, 2'b00, '0, '0, 1);
    checkOutput("route_release", consumed_out, 2'b00);
    step();
    applyStimulus(0, 2'b00, 2'b00, '0, '0, 1);
    checkOutput("route_idle_after", consumed_out, 2'b00);
    step();

    // Boundary: req_in[1] rises on the same cycle as producer 0's last word
    do_reset();
    applyStimulus(0, 2'b01, 2'b00, '0, '0, 0);
    step();
    for (int k = 0; k < W - 1; k++) begin
      applyStimulus(0, 2'b01, 2'b01, 32'hF0 + k, '0, 0);
      step();
    end
    applyStimulus(0, 2'b11, 2'b01, 32'hF3, '0, 0);
    step();
    checkOutput("bound_grant_plus0", grant_out, 2'b00);
    applyStimulus(0, 2'b10, 2'b00, '0, '0, 0);
    step();
    checkOutput("bound_grant_plus1", grant_out, 2'b00);
    applyStimulus(0, 2'b10, 2'b00, '0, '0, 0);
    step();
    checkOutput("bound_grant_plus2", grant_out, 2'b10);
    for (int k = 0; k < W; k++) begin
      applyStimulus(0, 2'b10, 2'b10, '0, 32'h100 + k, 0);
      step();
      checkOutput("bound_new_count", grant_out, (k == W - 1) ? 2'b00 : 2'b10);
    end

    // Round-robin with both requests held
    do_reset();
    prev_g = '0;
    for (int c = 0; c < 200 && order.size() < 4; c++) begin
      drive_cycle(1, 0);
      step();
      if (grant_out != '0 && prev_g == '0) begin
        order.push_back(grant_out[1] ? 1 : 0);
        if (lw_step >= 0) checkOutput("rr_gap", cycle - lw_step, 2);
      end
      prev_g = grant_out;
    end
    checkOutput("rr_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) checkOutput("rr_order", order[i], i % 2);

    // Randomized traffic, first clean, then with stray valids from idle producers
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive_cycle(0, 0);
      step();
    end
    checkOutput("random_clean_error", protocol_error_out, 0);
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive_cycle(0, 1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
